// File: rtl/clk_mux_pkg.sv
// Shared types and constants for the clock-mux control slice: FSM state
// encoding, select values and a counter-width helper.
package clk_mux_pkg;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        RUN_PRI   = 3'd1,
        RUN_BAK   = 3'd2,
        SWITCH    = 3'd3,
        MMCM_RST  = 3'd4,
        WAIT_LOCK = 3'd5,
        FAULT     = 3'd6
    } state_e;

    localparam logic SEL_PRI = 1'b0;
    localparam logic SEL_BAK = 1'b1;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/clk_failover_ctrl_if.sv
// Monitor/MMCM-side signal bundle of the failover controller. The controller
// connects through master; the environment (monitors, mux, MMCM) through slave.
interface clk_failover_ctrl_if;

    logic       stopped_pri;
    logic       stopped_bak;
    logic       force_backup;
    logic       mmcm_locked;
    logic       clk_sel;
    logic       mmcm_rst;
    logic       running;
    logic       fault;
    logic [7:0] switch_count;
    logic [2:0] state_o;

    modport master (
        input  stopped_pri, stopped_bak, force_backup, mmcm_locked,
        output clk_sel, mmcm_rst, running, fault, switch_count, state_o
    );

    modport slave (
        output stopped_pri, stopped_bak, force_backup, mmcm_locked,
        input  clk_sel, mmcm_rst, running, fault, switch_count, state_o
    );

endinterface

// File: rtl/clk_health_debounce.sv
// Qualifies a clock-stopped level: the output follows the input only after
// the input has held its new value for DEBOUNCE_CYCLES consecutive cycles.
module clk_health_debounce
    import clk_mux_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic qual_o
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qual_q, qual_d;

    // Any cycle agreeing with the current qualified level restarts the run.
    always_comb begin
        if (level_i == qual_q) begin
            cnt_d  = '0;
            qual_d = qual_q;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            qual_d = level_i;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            qual_d = qual_q;
        end
    end

    // Run-length counter and qualified flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            qual_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            qual_q <= qual_d;
        end
    end

    assign qual_o = qual_q;

endmodule

// File: rtl/clk_failover_ctrl.sv
// Clock failover sequencer in the free-running clk_ref domain: debounces the
// stop monitors, drives the BUFGMUX select and MMCM reset, relocks and reverts.
module clk_failover_ctrl
    import clk_mux_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES       = 4,
    parameter int SWITCH_SETTLE_CYCLES  = 16,
    parameter int MMCM_RESET_CYCLES     = 8,
    parameter int LOCK_TIMEOUT_CYCLES   = 1000000,
    parameter int REVERT_HOLDOFF_CYCLES = 100000000,
    parameter int AUTO_REVERT           = 1
) (
    input  logic                 clk_ref,
    input  logic                 reset_n_in,
    clk_failover_ctrl_if.master  bus
);

    localparam int TMR_MAX0 = (SWITCH_SETTLE_CYCLES > MMCM_RESET_CYCLES) ?
                              SWITCH_SETTLE_CYCLES : MMCM_RESET_CYCLES;
    localparam int TMR_MAX  = (LOCK_TIMEOUT_CYCLES > TMR_MAX0) ? LOCK_TIMEOUT_CYCLES : TMR_MAX0;
    localparam int TMR_W    = cnt_width(TMR_MAX);
    localparam int REV_W    = cnt_width(REVERT_HOLDOFF_CYCLES);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SWITCH_SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(MMCM_RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [REV_W-1:0] REV_LAST    = REV_W'(REVERT_HOLDOFF_CYCLES - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic             clk_sel_q, clk_sel_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             running_q, running_d;
    logic             fault_q, fault_d;
    logic [7:0]       switch_count_q, switch_count_d;

    logic pri_bad_s, bak_bad_s, sw_req_s, sw_tgt_s, rev_hit_s, other_bad_s;

    clk_health_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_pri (
        .clk(clk_ref), .rst_n(reset_n_in), .level_i(bus.stopped_pri), .qual_o(pri_bad_s)
    );

    clk_health_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_bak (
        .clk(clk_ref), .rst_n(reset_n_in), .level_i(bus.stopped_bak), .qual_o(bak_bad_s)
    );

    assign rev_hit_s   = (AUTO_REVERT != 0) && !bus.force_backup && !pri_bad_s &&
                         (rev_cnt_q == REV_LAST);
    assign other_bad_s = (clk_sel_q == SEL_PRI) ? bak_bad_s : pri_bad_s;

    // Next-state decision; branch order inside each state encodes event precedence.
    always_comb begin
        state_d  = state_q;
        sw_req_s = 1'b0;
        sw_tgt_s = clk_sel_q;
        case (state_q)
            INIT, MMCM_RST: begin
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
                else                     state_d = state_q;
            end
            RUN_PRI: begin
                if (pri_bad_s && bak_bad_s) begin
                    state_d = FAULT;
                end else if ((pri_bad_s || bus.force_backup) && !bak_bad_s) begin
                    sw_req_s = 1'b1;
                    sw_tgt_s = SEL_BAK;
                end else if (!bus.mmcm_locked) begin
                    state_d = MMCM_RST;
                end else begin
                    state_d = state_q;
                end
            end
            RUN_BAK: begin
                if (pri_bad_s && bak_bad_s) begin
                    state_d = FAULT;
                end else if (bak_bad_s && !pri_bad_s) begin
                    sw_req_s = 1'b1;
                    sw_tgt_s = SEL_PRI;
                end else if (!bus.mmcm_locked) begin
                    state_d = MMCM_RST;
                end else if (rev_hit_s) begin
                    sw_req_s = 1'b1;
                    sw_tgt_s = SEL_PRI;
                end else begin
                    state_d = state_q;
                end
            end
            SWITCH: begin
                if (timer_q == SETTLE_LAST) state_d = MMCM_RST;
                else                        state_d = state_q;
            end
            WAIT_LOCK: begin
                if (bus.mmcm_locked) begin
                    state_d = (clk_sel_q == SEL_BAK) ? RUN_BAK : RUN_PRI;
                end else if (timer_q == LOCK_LAST) begin
                    if (other_bad_s) begin
                        state_d = FAULT;
                    end else begin
                        sw_req_s = 1'b1;
                        sw_tgt_s = ~clk_sel_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            FAULT: begin
                if (!pri_bad_s || !bak_bad_s) begin
                    sw_req_s = 1'b1;
                    sw_tgt_s = (!pri_bad_s && !bus.force_backup) ? SEL_PRI : SEL_BAK;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = INIT;
        endcase
        if (sw_req_s) begin
            state_d = SWITCH;
        end else begin
            state_d = state_d;
        end
    end

    // Timers, select, counters and outputs derived from the chosen next state.
    always_comb begin
        if ((state_d != state_q) || (state_q inside {RUN_PRI, RUN_BAK, FAULT})) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
        if ((state_q == RUN_BAK) && (state_d == RUN_BAK) && !pri_bad_s && !bus.force_backup) begin
            rev_cnt_d = (rev_cnt_q == REV_LAST) ? rev_cnt_q : (rev_cnt_q + REV_W'(1));
        end else begin
            rev_cnt_d = '0;
        end
        clk_sel_d      = sw_req_s ? sw_tgt_s : clk_sel_q;
        switch_count_d = (sw_req_s && (switch_count_q != 8'hFF)) ?
                         (switch_count_q + 8'd1) : switch_count_q;
        mmcm_rst_d     = state_d inside {INIT, SWITCH, MMCM_RST, FAULT};
        running_d      = (state_d inside {RUN_PRI, RUN_BAK}) && bus.mmcm_locked;
        fault_d        = (state_d == FAULT);
    end

    // Reset parks on primary with the MMCM held in reset.
    always_ff @(posedge clk_ref or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q        <= INIT;
            timer_q        <= '0;
            rev_cnt_q      <= '0;
            clk_sel_q      <= SEL_PRI;
            mmcm_rst_q     <= 1'b1;
            running_q      <= 1'b0;
            fault_q        <= 1'b0;
            switch_count_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            rev_cnt_q      <= rev_cnt_d;
            clk_sel_q      <= clk_sel_d;
            mmcm_rst_q     <= mmcm_rst_d;
            running_q      <= running_d;
            fault_q        <= fault_d;
            switch_count_q <= switch_count_d;
        end
    end

    assign bus.clk_sel      = clk_sel_q;
    assign bus.mmcm_rst     = mmcm_rst_q;
    assign bus.running      = running_q;
    assign bus.fault        = fault_q;
    assign bus.switch_count = switch_count_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_clk_failover_ctrl.sv
// Directed bench for clk_failover_ctrl: a vector table walked step by step plus
// hand sequences for init timing, auto-revert, saturation and async reset.
module tb_clk_failover_ctrl;
    import clk_mux_pkg::*;

    logic clk_ref = 1'b0;
    logic reset_n_in;
    always #5 clk_ref = ~clk_ref;

    clk_failover_ctrl_if bus();

    clk_failover_ctrl #(
        .DEBOUNCE_CYCLES(4), .SWITCH_SETTLE_CYCLES(16), .MMCM_RESET_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(200), .REVERT_HOLDOFF_CYCLES(64), .AUTO_REVERT(1)
    ) dut (
        .clk_ref(clk_ref), .reset_n_in(reset_n_in), .bus(bus)
    );

    typedef struct {
        logic       sp, sb, fb, lk;
        int         cycles;
        state_e     st;
        logic       sel, rst, run, flt;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input state_e st, input logic sel, rst, run, flt,
                              input logic [7:0] cnt);
        chk({tag, ".state"},    32'(bus.state_o),      32'(st));
        chk({tag, ".clk_sel"},  32'(bus.clk_sel),      32'(sel));
        chk({tag, ".mmcm_rst"}, 32'(bus.mmcm_rst),     32'(rst));
        chk({tag, ".running"},  32'(bus.running),      32'(run));
        chk({tag, ".fault"},    32'(bus.fault),        32'(flt));
        chk({tag, ".count"},    32'(bus.switch_count), 32'(cnt));
    endtask

    task automatic wait_state(input state_e tgt, input int budget, input string name);
        int n = 0;
        while (bus.state_o !== tgt && n < budget) begin
            @(negedge clk_ref);
            n++;
        end
        chk(name, (bus.state_o === tgt) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic add(input logic sp, sb, fb, lk, input int cyc, input state_e st,
                       input logic sel, rst, run, flt, input logic [7:0] cnt);
        vec_t v;
        v.sp = sp; v.sb = sb; v.fb = fb; v.lk = lk; v.cycles = cyc; v.st = st;
        v.sel = sel; v.rst = rst; v.run = run; v.flt = flt; v.cnt = cnt;
        vq.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // sp sb fb lk cyc   state      sel rst run flt cnt
        add(1, 0, 0, 1,   3, RUN_PRI,   0, 0, 1, 0, 8'd0);  // 3-cycle glitch ignored
        add(0, 0, 0, 1,   1, RUN_PRI,   0, 0, 1, 0, 8'd0);
        add(1, 0, 0, 1,   4, RUN_PRI,   0, 0, 1, 0, 8'd0);
        add(1, 0, 0, 1,   1, SWITCH,    1, 1, 0, 0, 8'd1);
        add(1, 0, 0, 0,  15, SWITCH,    1, 1, 0, 0, 8'd1);
        add(1, 0, 0, 0,   1, MMCM_RST,  1, 1, 0, 0, 8'd1);
        add(1, 0, 0, 0,   7, MMCM_RST,  1, 1, 0, 0, 8'd1);
        add(1, 0, 0, 0,   1, WAIT_LOCK, 1, 0, 0, 0, 8'd1);
        add(1, 0, 0, 1,   1, RUN_BAK,   1, 0, 1, 0, 8'd1);
        add(1, 1, 0, 1,   4, RUN_BAK,   1, 0, 1, 0, 8'd1);
        add(1, 1, 0, 1,   1, FAULT,     1, 1, 0, 1, 8'd1);
        add(1, 0, 0, 1,   3, FAULT,     1, 1, 0, 1, 8'd1);
        add(1, 0, 0, 1,   1, FAULT,     1, 1, 0, 1, 8'd1);
        add(1, 0, 0, 1,   1, SWITCH,    1, 1, 0, 0, 8'd2);
        add(1, 0, 0, 1,  25, RUN_BAK,   1, 0, 1, 0, 8'd2);
        add(0, 0, 1, 1,  10, RUN_BAK,   1, 0, 1, 0, 8'd2);
        add(0, 0, 1, 1, 100, RUN_BAK,   1, 0, 1, 0, 8'd2);  // force blocks revert
        add(0, 0, 1, 0,   1, MMCM_RST,  1, 1, 0, 0, 8'd2);
        add(0, 0, 1, 0,   8, WAIT_LOCK, 1, 0, 0, 0, 8'd2);
        add(0, 0, 1, 0, 199, WAIT_LOCK, 1, 0, 0, 0, 8'd2);
        add(0, 0, 1, 0,   1, SWITCH,    0, 1, 0, 0, 8'd3);  // lock timeout
        add(0, 0, 0, 1,  25, RUN_PRI,   0, 0, 1, 0, 8'd3);
        add(0, 1, 0, 1,   4, RUN_PRI,   0, 0, 1, 0, 8'd3);
        add(0, 1, 1, 1,  10, RUN_PRI,   0, 0, 1, 0, 8'd3);  // force ignored, backup bad
        add(1, 1, 0, 1,   4, RUN_PRI,   0, 0, 1, 0, 8'd3);
        add(1, 1, 0, 1,   1, FAULT,     0, 1, 0, 1, 8'd3);
        add(0, 1, 0, 1,   4, FAULT,     0, 1, 0, 1, 8'd3);
        add(0, 1, 0, 1,   1, SWITCH,    0, 1, 0, 0, 8'd4);  // same-source switch counts
        add(0, 1, 0, 1,  25, RUN_PRI,   0, 0, 1, 0, 8'd4);
        add(0, 0, 0, 1,   4, RUN_PRI,   0, 0, 1, 0, 8'd4);
        add(1, 1, 0, 1,   5, FAULT,     0, 1, 0, 1, 8'd4);
        add(1, 0, 0, 1,   5, SWITCH,    1, 1, 0, 0, 8'd5);
        add(1, 0, 0, 0,  24, WAIT_LOCK, 1, 0, 0, 0, 8'd5);
        add(1, 0, 0, 0, 200, FAULT,     1, 1, 0, 1, 8'd5);  // timeout, other source bad
        add(1, 0, 0, 0,   1, SWITCH,    1, 1, 0, 0, 8'd6);
        add(1, 0, 0, 1,  25, RUN_BAK,   1, 0, 1, 0, 8'd6);

        reset_n_in       = 1'b0;
        bus.stopped_pri  = 1'b0;
        bus.stopped_bak  = 1'b0;
        bus.force_backup = 1'b0;
        bus.mmcm_locked  = 1'b0;
        repeat (2) @(negedge clk_ref);
        check_outs("reset", INIT, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        reset_n_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (bus.mmcm_rst !== 1'b0 && n < 50);
        chk("init_rst_width", 32'(n), 32'd8);
        repeat (4) @(negedge clk_ref);
        chk("wait_lock_idle", 32'(bus.state_o), 32'(WAIT_LOCK));
        bus.mmcm_locked = 1'b1;
        @(negedge clk_ref);
        check_outs("first_lock", RUN_PRI, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.stopped_pri  = vq[i].sp;
            bus.stopped_bak  = vq[i].sb;
            bus.force_backup = vq[i].fb;
            bus.mmcm_locked  = vq[i].lk;
            repeat (vq[i].cycles) @(negedge clk_ref);
            check_outs($sformatf("v%0d", i), vq[i].st, vq[i].sel, vq[i].rst, vq[i].run,
                       vq[i].flt, vq[i].cnt);
        end

        // Primary recovers while on backup: revert after debounce plus holdoff.
        bus.stopped_pri = 1'b0;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (bus.state_o !== SWITCH && n < 200);
        chk("revert_latency", 32'(n), 32'd68);
        chk("revert_sel", 32'(bus.clk_sel), 32'd0);
        chk("revert_count", 32'(bus.switch_count), 32'd7);
        wait_state(RUN_PRI, 40, "revert_relock");

        for (int k = 0; k < 150; k++) begin
            bus.force_backup = 1'b1;
            wait_state(RUN_BAK, 60, $sformatf("sat_to_bak%0d", k));
            bus.force_backup = 1'b0;
            wait_state(RUN_PRI, 150, $sformatf("sat_to_pri%0d", k));
        end
        chk("count_saturated", 32'(bus.switch_count), 32'd255);

        // Reset asserted between clock edges must clear outputs at once.
        bus.force_backup = 1'b1;
        wait_state(SWITCH, 10, "enter_switch");
        #2 reset_n_in = 1'b0;
        #1 check_outs("async_reset", INIT, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge clk_ref);
        reset_n_in = 1'b1;
        @(negedge clk_ref);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_failover_ctrl.md
Name: clk_failover_ctrl

Overview:
- Control-side companion to the clock-stop monitors in clk_mux.
- Consumes the per-source `stopped` flags from two monitors, one on the primary clock and one on the backup clock.
- Drives the clock mux select (BUFGMUX S pin) and the downstream MMCM reset.
- Sequences safe failover, relock, optional auto-revert and a dual-failure fault state, all in the clk_ref (free-running) domain.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a stopped/healthy level must persist before it is acted on.
- SWITCH_SETTLE_CYCLES, 16: cycles after a select change before MMCM reset is applied.
- MMCM_RESET_CYCLES, 8: width of the MMCM reset pulse.
- LOCK_TIMEOUT_CYCLES, 1000000: maximum wait for `mmcm_locked` after reset release.
- REVERT_HOLDOFF_CYCLES, 100000000: primary must stay qualified healthy this long before auto-revert.
- AUTO_REVERT, 1: 1 = return to primary when healthy; 0 = stay on backup.

Ports:
- clk_ref, in, 1: free-running reference clock; all logic lives in this domain.
- reset_n_in, in, 1: asynchronous, active-low reset.
- stopped_pri, in, 1: primary-clock monitor flag; synchronous to clk_ref.
- stopped_bak, in, 1: backup-clock monitor flag; synchronous to clk_ref.
- force_backup, in, 1: software request to run from backup; level-sensitive.
- mmcm_locked, in, 1: MMCM lock; externally synchronized to clk_ref.
- clk_sel, out, 1: 0 = primary, 1 = backup.
- mmcm_rst, out, 1: MMCM reset, active high.
- running, out, 1: in a RUN state and locked.
- fault, out, 1: neither source usable.
- switch_count, out, 8: number of select changes, saturating at 255.
- state_o, out, 3: current FSM state encoding.

Behaviour:
- Reset (async assert, sync release): state INIT, clk_sel=0, mmcm_rst=1, running=0, fault=0, switch_count=0, all counters 0.
- Debounce per source:
  - pri_bad sets after stopped_pri=1 for DEBOUNCE_CYCLES consecutive cycles.
  - pri_bad clears after stopped_pri=0 for DEBOUNCE_CYCLES consecutive cycles.
  - Same rules for bak_bad. Both flags reset to 0.
- INIT: mmcm_rst=1 for MMCM_RESET_CYCLES, then WAIT_LOCK on primary.
- RUN_PRI:
  - pri_bad && bak_bad -> FAULT.
  - (pri_bad || force_backup) && !bak_bad -> SWITCH, target backup.
  - !mmcm_locked -> MMCM_RST (same source).
- RUN_BAK:
  - pri_bad && bak_bad -> FAULT.
  - bak_bad && !pri_bad -> SWITCH, target primary.
  - AUTO_REVERT && !force_backup && revert counter reached REVERT_HOLDOFF_CYCLES -> SWITCH, target primary.
  - !mmcm_locked -> MMCM_RST.
  - Revert counter increments while !pri_bad and clears to 0 on pri_bad, on force_backup, or on exit from RUN_BAK.
- SWITCH:
  - clk_sel takes the target value on entry; switch_count increments on entry (saturating).
  - mmcm_rst=1 throughout.
  - Holds SWITCH_SETTLE_CYCLES, then goes to MMCM_RST.
- MMCM_RST: mmcm_rst=1 for MMCM_RESET_CYCLES, then WAIT_LOCK.
- WAIT_LOCK:
  - mmcm_rst=0.
  - mmcm_locked=1 -> RUN_PRI or RUN_BAK per clk_sel.
  - LOCK_TIMEOUT_CYCLES elapse: SWITCH to the other source if it is not bad, else FAULT.
- FAULT:
  - fault=1, mmcm_rst=1, clk_sel unchanged.
  - Exit when either source clears bad: SWITCH to primary if !pri_bad && !force_backup, else to backup.
  - A SWITCH whose target equals the current clk_sel still increments switch_count.
- running=1 only in RUN_PRI/RUN_BAK while mmcm_locked=1. fault=1 only in FAULT.
- Precedence on simultaneous events: dual failure > source failure > force_backup > lock loss > auto-revert.
- force_backup while bak_bad: ignored; stay on primary.
- Select changes only on SWITCH entry, never in any other state. clk_sel never toggles within SWITCH_SETTLE_CYCLES of a prior change.
- Counters are sized by $clog2 of their parameter (minimum 1 bit). The terminal compare is equality, followed by clear.

Decomposition:
- Shared package clk_mux_pkg holds:
  - the state enum: INIT=0, RUN_PRI=1, RUN_BAK=2, SWITCH=3, MMCM_RST=4, WAIT_LOCK=5, FAULT=6;
  - the select constants SEL_PRI=0, SEL_BAK=1.
- Sub-module clk_health_debounce (parameter DEBOUNCE_CYCLES; level in, qualified level out) is instantiated twice.

Test Plan (bench parameters: DEBOUNCE=4, SETTLE=16, RST=8, TIMEOUT=200, HOLDOFF=64):
- Release reset, assert mmcm_locked 5 cycles after mmcm_rst falls -> mmcm_rst high exactly 8 cycles, then state RUN_PRI, running=1, clk_sel=0, switch_count=0.
- In RUN_PRI, stopped_pri=1 for 3 cycles then 0 -> no state change. Hold it 4 cycles -> SWITCH, clk_sel=1, switch_count=1, mmcm_rst high 16+8 cycles, then relock -> RUN_BAK.
- In RUN_BAK with AUTO_REVERT=1, clear stopped_pri -> SWITCH to primary exactly 4+64 cycles later. Repeat with force_backup=1 -> stays in RUN_BAK indefinitely.
- stopped_pri and stopped_bak asserted on the same cycle -> FAULT after 4 cycles, fault=1, mmcm_rst=1, clk_sel unchanged. Clear stopped_bak -> exit to SWITCH target backup.
- Hold mmcm_locked=0 in WAIT_LOCK -> after 200 cycles SWITCH to the other source. With that source also bad -> FAULT.
- Force 300 failovers -> switch_count saturates at 255. Assert reset_n_in=0 mid-SWITCH -> all outputs return to reset values immediately, without waiting for a clock edge.
